// File: rtl/if_fetch_pkg.sv
// Shared constants, types and helpers for the IF fetch stage.
package if_fetch_pkg;

  localparam int STALL_W     = 6;
  localparam int BR_WD       = 33;
  localparam int IF_TO_ID_WD = 33;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [31:0] PC_RESET_VEC = 32'hBFBF_FFFC;

  typedef enum logic {
    BUF_RUN  = 1'b0,
    BUF_HOLD = 1'b1
  } buf_state_e;

  // A redirect parked during a freeze outranks a live branch; sequential fetch wraps mod 2^32.
  function automatic logic [31:0] pc_select(
    input logic        pend_v,
    input logic [31:0] pend_addr,
    input logic        br_e,
    input logic [31:0] br_addr,
    input logic [31:0] pc
  );
    if (pend_v)    return pend_addr;
    else if (br_e) return br_addr;
    else           return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_inst_buf.sv
// One-entry instruction hold buffer: keeps the SRAM read data alive while IF is stalled.
module if_inst_buf
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        ce,
  input  logic [31:0] rdata,
  output logic        buf_v,
  output logic [31:0] id_inst
);

  buf_state_e  state;
  logic [31:0] buf_data;

  // RUN/HOLD FSM: capture once on stall entry, never overwrite while holding.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= BUF_RUN;
      buf_v    <= 1'b0;
      buf_data <= 32'b0;
    end else begin
      case (state)
        BUF_RUN: begin
          if (stall_if == STOP && ce) begin
            buf_data <= rdata;
            buf_v    <= 1'b1;
            state    <= BUF_HOLD;
          end
        end
        BUF_HOLD: begin
          if (stall_if == NO_STOP) begin
            buf_v <= 1'b0;
            state <= BUF_RUN;
          end
        end
        default: begin
          buf_v <= 1'b0;
          state <= BUF_RUN;
        end
      endcase
    end
  end

  assign id_inst = buf_v ? buf_data : rdata;

endmodule

// File: rtl/if_fetch.sv
// IF stage: PC register, pending-redirect capture, SRAM drive and IF->ID bus.
// Optional build macro IF_ADEL_EN adds the if_excp_adel misaligned-fetch flag.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_VEC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall,
  input  logic [BR_WD-1:0]       br_bus,
  input  logic [31:0]            inst_sram_rdata,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_wen,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic [31:0]            id_inst
`ifdef IF_ADEL_EN
  ,
  output logic                   if_excp_adel
`endif
);

  logic        br_e;
  logic [31:0] br_addr;
  logic [31:0] pc;
  logic        ce;
  logic [31:0] next_pc;
  logic        pend_v;
  logic [31:0] pend_addr;
  logic        buf_v;
  logic        unused_stall;

  assign {br_e, br_addr} = br_bus;
  assign unused_stall    = ^stall[STALL_W-1:2];

  assign next_pc = pc_select(pend_v, pend_addr, br_e, br_addr, pc);

  // PC and fetch-enable advance only when the PC stage is not stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RESET_PC;
      ce <= 1'b0;
    end else if (stall[0] == NO_STOP) begin
      ce <= 1'b1;
      pc <= next_pc;
    end
  end

  // Park a branch raised while the PC is frozen; consume it on the first unfrozen cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_v    <= 1'b0;
      pend_addr <= 32'b0;
    end else if (stall[0] == STOP) begin
      if (br_e) begin
        pend_v    <= 1'b1;
        pend_addr <= br_addr;
      end
    end else begin
      pend_v <= 1'b0;
    end
  end

  // Registered {ce, pc} handed to ID, one cycle behind the PC register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if_to_id_bus <= '0;
    end else begin
      if_to_id_bus <= {ce, pc};
    end
  end

`ifdef IF_ADEL_EN
  assign if_excp_adel = ce & (pc[1:0] != 2'b00);
  assign inst_sram_en = ce & ~if_excp_adel;
`else
  assign inst_sram_en = ce;
`endif

  assign inst_sram_wen   = 4'b0;
  assign inst_sram_addr  = pc;
  assign inst_sram_wdata = 32'b0;

  if_inst_buf u_inst_buf (
    .clk      (clk),
    .rst      (rst),
    .stall_if (stall[1]),
    .ce       (ce),
    .rdata    (inst_sram_rdata),
    .buf_v    (buf_v),
    .id_inst  (id_inst)
  );

endmodule

// File: tb/tb_if_fetch.sv
// Directed testbench for if_fetch.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        br_e;
  logic [31:0] br_addr;
  logic [32:0] br_bus;
  logic [31:0] rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [32:0] to_id;
  logic [31:0] id_inst;
`ifdef IF_ADEL_EN
  logic        adel;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  assign br_bus = {br_e, br_addr};

  if_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .inst_sram_rdata (rdata),
    .inst_sram_en    (sram_en),
    .inst_sram_wen   (sram_wen),
    .inst_sram_addr  (sram_addr),
    .inst_sram_wdata (sram_wdata),
    .if_to_id_bus    (to_id),
    .id_inst         (id_inst)
`ifdef IF_ADEL_EN
    ,
    .if_excp_adel    (adel)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 6'b0; br_e = 1'b0; br_addr = 32'b0; rdata = 32'h1234_5678;
    tick(); tick(); tick();
    n_checks++; if (sram_en !== 1'b0) begin n_fail++; $display("FAIL rst_en: got %b want 0", sram_en); end
    n_checks++; if (sram_addr !== 32'hBFBF_FFFC) begin n_fail++; $display("FAIL rst_addr: got %h want bfbffffc", sram_addr); end
    n_checks++; if (to_id !== 33'b0) begin n_fail++; $display("FAIL rst_bus: got %h want 0", to_id); end
    n_checks++; if (id_inst !== 32'h1234_5678) begin n_fail++; $display("FAIL rst_id_inst: got %h want 12345678", id_inst); end
    n_checks++; if (sram_wen !== 4'b0 || sram_wdata !== 32'b0) begin n_fail++; $display("FAIL rst_ties: wen %h wdata %h want 0", sram_wen, sram_wdata); end
  endtask

  task automatic test_seq_fetch();
    rst = 1'b1;
    tick();
    n_checks++; if (sram_addr !== 32'hBFC0_0000) begin n_fail++; $display("FAIL seq_addr0: got %h want bfc00000", sram_addr); end
    n_checks++; if (sram_en !== 1'b1) begin n_fail++; $display("FAIL seq_en: got %b want 1", sram_en); end
    n_checks++; if (to_id !== {1'b0, 32'hBFBF_FFFC}) begin n_fail++; $display("FAIL seq_bus0: got %h want 0bfbffffc", to_id); end
    tick();
    n_checks++; if (sram_addr !== 32'hBFC0_0004) begin n_fail++; $display("FAIL seq_addr1: got %h want bfc00004", sram_addr); end
    n_checks++; if (to_id !== {1'b1, 32'hBFC0_0000}) begin n_fail++; $display("FAIL seq_bus1: got %h want 1bfc00000", to_id); end
    tick();
    n_checks++; if (sram_addr !== 32'hBFC0_0008) begin n_fail++; $display("FAIL seq_addr2: got %h want bfc00008", sram_addr); end
    n_checks++; if (to_id !== {1'b1, 32'hBFC0_0004}) begin n_fail++; $display("FAIL seq_bus2: got %h want 1bfc00004", to_id); end
  endtask

  task automatic test_branch();
    br_e = 1'b1; br_addr = 32'hBFC0_0100;
    tick();
    br_e = 1'b0;
    n_checks++; if (sram_addr !== 32'hBFC0_0100) begin n_fail++; $display("FAIL br_addr: got %h want bfc00100", sram_addr); end
    tick();
    n_checks++; if (sram_addr !== 32'hBFC0_0104) begin n_fail++; $display("FAIL br_next: got %h want bfc00104", sram_addr); end
    n_checks++; if (to_id !== {1'b1, 32'hBFC0_0100}) begin n_fail++; $display("FAIL br_bus: got %h want 1bfc00100", to_id); end
  endtask

  task automatic test_redirect_stall();
    stall = 6'b000011; br_e = 1'b1; br_addr = 32'hBFC0_0200;
    tick();
    br_e = 1'b0; br_addr = 32'h0;
    n_checks++; if (sram_addr !== 32'hBFC0_0104) begin n_fail++; $display("FAIL rs_frozen0: got %h want bfc00104", sram_addr); end
    tick(); tick();
    n_checks++; if (sram_addr !== 32'hBFC0_0104) begin n_fail++; $display("FAIL rs_frozen2: got %h want bfc00104", sram_addr); end
    stall = 6'b0;
    tick();
    n_checks++; if (sram_addr !== 32'hBFC0_0200) begin n_fail++; $display("FAIL rs_release: got %h want bfc00200", sram_addr); end
    tick();
    n_checks++; if (sram_addr !== 32'hBFC0_0204) begin n_fail++; $display("FAIL rs_pend_clear: got %h want bfc00204", sram_addr); end
  endtask

  task automatic test_pend_priority();
    stall = 6'b000001; br_e = 1'b1; br_addr = 32'hBFC0_0300;
    tick();
    br_addr = 32'hBFC0_0400;
    tick();
    n_checks++; if (sram_addr !== 32'hBFC0_0204) begin n_fail++; $display("FAIL pp_frozen: got %h want bfc00204", sram_addr); end
    stall = 6'b0; br_addr = 32'hBFC0_0500;
    tick();
    br_e = 1'b0;
    n_checks++; if (sram_addr !== 32'hBFC0_0400) begin n_fail++; $display("FAIL pp_pend_wins: got %h want bfc00400", sram_addr); end
    tick();
    n_checks++; if (sram_addr !== 32'hBFC0_0404) begin n_fail++; $display("FAIL pp_after: got %h want bfc00404", sram_addr); end
  endtask

  task automatic test_hold_buffer();
    stall = 6'b000011; rdata = 32'h3C01_BFC0;
    #1;
    n_checks++; if (id_inst !== 32'h3C01_BFC0) begin n_fail++; $display("FAIL hb_run: got %h want 3c01bfc0", id_inst); end
    tick();
    rdata = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (id_inst !== 32'h3C01_BFC0) begin n_fail++; $display("FAIL hb_hold0: got %h want 3c01bfc0", id_inst); end
    tick();
    n_checks++; if (id_inst !== 32'h3C01_BFC0) begin n_fail++; $display("FAIL hb_hold1: got %h want 3c01bfc0", id_inst); end
    stall = 6'b0;
    #1;
    n_checks++; if (id_inst !== 32'h3C01_BFC0) begin n_fail++; $display("FAIL hb_hold2: got %h want 3c01bfc0", id_inst); end
    tick();
    n_checks++; if (id_inst !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL hb_release: got %h want deadbeef", id_inst); end
  endtask

  task automatic test_wrap();
    br_e = 1'b1; br_addr = 32'hFFFF_FFFC;
    tick();
    br_e = 1'b0;
    n_checks++; if (sram_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top: got %h want fffffffc", sram_addr); end
    tick();
    n_checks++; if (sram_addr !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_zero: got %h want 00000000", sram_addr); end
  endtask

  task automatic test_reset_mid_hold();
    stall = 6'b000011; br_e = 1'b1; br_addr = 32'hBFC0_0700; rdata = 32'hAAAA_5555;
    tick();
    br_e = 1'b0; rdata = 32'h1111_1111;
    #1;
    n_checks++; if (id_inst !== 32'hAAAA_5555) begin n_fail++; $display("FAIL rmh_held: got %h want aaaa5555", id_inst); end
    rst = 1'b0; stall = 6'b0;
    tick();
    n_checks++; if (id_inst !== 32'h1111_1111) begin n_fail++; $display("FAIL rmh_buf_clr: got %h want 11111111", id_inst); end
    n_checks++; if (to_id !== 33'b0) begin n_fail++; $display("FAIL rmh_bus: got %h want 0", to_id); end
    n_checks++; if (sram_addr !== 32'hBFBF_FFFC || sram_en !== 1'b0) begin n_fail++; $display("FAIL rmh_pc: got %h en %b want bfbffffc en 0", sram_addr, sram_en); end
    rst = 1'b1;
    tick();
    n_checks++; if (sram_addr !== 32'hBFC0_0000) begin n_fail++; $display("FAIL rmh_restart: got %h want bfc00000", sram_addr); end
    tick();
    n_checks++; if (to_id !== {1'b1, 32'hBFC0_0000}) begin n_fail++; $display("FAIL rmh_bus_restart: got %h want 1bfc00000", to_id); end
  endtask

`ifdef IF_ADEL_EN
  task automatic test_adel();
    br_e = 1'b1; br_addr = 32'hBFC0_0102;
    tick();
    br_e = 1'b0;
    n_checks++; if (adel !== 1'b1 || sram_en !== 1'b0) begin n_fail++; $display("FAIL adel_set: adel %b en %b want 1 0", adel, sram_en); end
    tick();
    n_checks++; if (sram_addr !== 32'hBFC0_0106) begin n_fail++; $display("FAIL adel_advance: got %h want bfc00106", sram_addr); end
    br_e = 1'b1; br_addr = 32'hBFC0_0200;
    tick();
    br_e = 1'b0;
    n_checks++; if (adel !== 1'b0 || sram_en !== 1'b1) begin n_fail++; $display("FAIL adel_clear: adel %b en %b want 0 1", adel, sram_en); end
  endtask
`endif

  initial begin
    test_reset();
    test_seq_fetch();
    test_branch();
    test_redirect_stall();
    test_pend_priority();
    test_hold_buffer();
    test_wrap();
    test_reset_mid_hold();
`ifdef IF_ADEL_EN
    test_adel();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
